dbg_bus_arbiter: RTL

//  Shares the single SoC memory port between the darkriscv CPU and the debug

---
 rtl/dbg_bus_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dbg_bus_arbiter.sv
// rtl/dbg_bus_arbiter.sv - memory port arbiter between CPU and debug loader
module dbg_bus_arbiter #(
  parameter int AW       = 32,
  parameter int RST_HOLD = 4,
  parameter int WCNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              dbg_mem_op,
  input  logic [AW-1:0]     dbg_adr,
  input  logic [31:0]       dbg_do,
  input  logic [3:0]        dbg_wren,
  input  logic [AW-1:0]     cpu_adr,
  input  logic [31:0]       cpu_do,
  input  logic [3:0]        cpu_wren,
  input  logic              cpu_rd,
  output logic              cpu_n_reset,
  output logic              cpu_halt,
  output logic [AW-1:0]     mem_adr,
  output logic [31:0]       mem_do,
  output logic [3:0]        mem_wren,
  output logic              mem_rd,
  output logic              dbg_busy,
  output logic [WCNT_W-1:0] dbg_wcnt
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DBG   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [HW-1:0]   hold_cnt, hold_cnt_nx;
  logic            cpu_rd_q;
  logic [AW-1:0]   dbg_adr_q;
  logic [31:0]     dbg_do_q;
  logic [3:0]      dbg_wren_q;
  logic            dbg_first;
  logic            dbg_changed;
  logic            wr_pulse;
  logic            dbg_entry_clr;

  // Next-state selection and hold-time counting
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    case (state)
      RUN: begin
        // a read issued last cycle must complete before the CPU is stalled
        if (dbg_mem_op) state_nx = cpu_rd_q ? DRAIN : DBG;
      end
      DRAIN: begin
        state_nx = DBG;
      end
      DBG: begin
        if (!dbg_mem_op) begin
          state_nx    = HOLD;
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        if (dbg_mem_op) begin
          state_nx    = DBG;
          hold_cnt_nx = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx    = RUN;
          hold_cnt_nx = '0;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nx    = HOLD;
        hold_cnt_nx = '0;
      end
    endcase
  end

  // Debug writes are issued once per new address/data/enable combination
  always_comb begin
    dbg_changed   = (dbg_adr != dbg_adr_q) || (dbg_do != dbg_do_q) || (dbg_wren != dbg_wren_q);
    wr_pulse      = (state == DBG) && (dbg_first || dbg_changed);
    dbg_entry_clr = (state_nx == DBG) && ((state == RUN) || (state == DRAIN));
  end

  // Memory port mux; idle states drive a quiet bus
  always_comb begin
    mem_adr  = '0;
    mem_do   = '0;
    mem_wren = '0;
    mem_rd   = 1'b0;
    dbg_busy = 1'b0;
    case (state)
      RUN: begin
        mem_adr  = cpu_adr;
        mem_do   = cpu_do;
        mem_wren = cpu_wren;
        mem_rd   = cpu_rd;
      end
      DRAIN: begin
        dbg_busy = 1'b1;
      end
      DBG: begin
        mem_adr  = dbg_adr;
        mem_do   = dbg_do;
        mem_wren = wr_pulse ? dbg_wren : 4'h0;
        dbg_busy = 1'b1;
      end
      default: begin
        mem_adr = '0;
      end
    endcase
  end

  // State register and hold counter
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // CPU control, registered from the upcoming state; reset stays released during DRAIN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cpu_n_reset <= 1'b0;
      cpu_halt    <= 1'b1;
    end else begin
      cpu_n_reset <= (state_nx == RUN) || (state_nx == DRAIN);
      cpu_halt    <= (state_nx != RUN);
    end
  end

  // Previous-cycle history for read draining and debug write change detection
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cpu_rd_q   <= 1'b0;
      dbg_adr_q  <= '0;
      dbg_do_q   <= '0;
      dbg_wren_q <= '0;
      dbg_first  <= 1'b0;
    end else begin
      cpu_rd_q   <= cpu_rd;
      dbg_adr_q  <= dbg_adr;
      dbg_do_q   <= dbg_do;
      dbg_wren_q <= dbg_wren;
      dbg_first  <= (state_nx == DBG) && (state != DBG);
    end
  end

  // Session write counter: cleared on a fresh session, kept across HOLD re-entry
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      dbg_wcnt <= '0;
    end else if (dbg_entry_clr) begin
      dbg_wcnt <= '0;
    end else if (wr_pulse && (dbg_wren != 4'h0)) begin
      dbg_wcnt <= dbg_wcnt + 1'b1;
    end
  end

endmodule
